// File: rtl/pe_cluster_ctrl_pkg.sv
// Shared widths, types and layer arithmetic for the PE cluster sequencer.
package pe_ctrl_pkg;

   localparam int DATA_WIDTH       = 16;
   localparam int MAX_FILTER_WIDTH = 11;
   localparam int LOG_MFW          = $clog2(MAX_FILTER_WIDTH);
   localparam int MAX_ROW_NUM      = 16;
   localparam int LOG_MRN          = $clog2(MAX_ROW_NUM);
   localparam int MAX_IFMAP_WIDTH  = 64;
   localparam int LOG_MIW          = $clog2(MAX_IFMAP_WIDTH);
   localparam int CNT_WIDTH        = 16;

   typedef logic [LOG_MFW:0]    k_t;
   typedef logic [LOG_MRN:0]    r_t;
   typedef logic [LOG_MIW:0]    w_t;
   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam k_t K_MAX = k_t'(MAX_FILTER_WIDTH);
   localparam r_t R_MAX = r_t'(MAX_ROW_NUM);
   localparam w_t W_MAX = w_t'(MAX_IFMAP_WIDTH);

   typedef enum logic [2:0] {IDLE, LOAD_W, CLR, STREAM, DRAIN, DONE} ctrl_state_e;

   // Ifmap words needed for R output rows: ((R-1)*S + K) input rows of W words.
   function automatic cnt_t calc_ni(input k_t k, input r_t r, input k_t s, input w_t w);
      cnt_t rows;
      rows = (cnt_t'(r) - cnt_t'(1)) * cnt_t'(s) + cnt_t'(k);
      return rows * cnt_t'(w);
   endfunction

   // Psums produced: R rows of floor((W-K)/S)+1 outputs each.
   function automatic cnt_t calc_no(input k_t k, input r_t r, input k_t s, input w_t w);
      cnt_t cols;
      cols = (cnt_t'(w) - cnt_t'(k)) / cnt_t'(s) + cnt_t'(1);
      return cnt_t'(r) * cols;
   endfunction

endpackage

// File: rtl/pe_cluster_ctrl_if.sv
// Stream and cluster-side signals of the PE cluster sequencer.
interface pe_cluster_ctrl_if;
   import pe_ctrl_pkg::*;

   logic [DATA_WIDTH-1:0] i_w_data;
   logic                  i_w_valid;
   logic                  o_w_ready;
   logic [DATA_WIDTH-1:0] i_if_data;
   logic                  i_if_valid;
   logic                  o_if_ready;
   logic [DATA_WIDTH-1:0] o_weight_data;
   logic                  o_weight_valid;
   k_t                    o_wr_w_row_ptr;
   k_t                    o_wr_w_col_ptr;
   logic [DATA_WIDTH-1:0] o_ifmap_data;
   logic                  o_ifmap_valid;
   logic                  o_reset_ifmap;
   logic                  i_peout_valid;

   modport slave (
      input  i_w_data, i_w_valid, i_if_data, i_if_valid, i_peout_valid,
      output o_w_ready, o_if_ready, o_weight_data, o_weight_valid,
             o_wr_w_row_ptr, o_wr_w_col_ptr, o_ifmap_data, o_ifmap_valid, o_reset_ifmap
   );

   modport master (
      output i_w_data, i_w_valid, i_if_data, i_if_valid, i_peout_valid,
      input  o_w_ready, o_if_ready, o_weight_data, o_weight_valid,
             o_wr_w_row_ptr, o_wr_w_col_ptr, o_ifmap_data, o_ifmap_valid, o_reset_ifmap
   );

endinterface

// File: rtl/pe_wptr_counter.sv
// Row/column write pointer into a KxK weight store; col wraps at K-1 and bumps row.
module pe_wptr_counter
   import pe_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   input  k_t   k,
   output k_t   row,
   output k_t   col,
   output logic last
);

   k_t   row_q, row_d;
   k_t   col_q, col_d;
   logic col_wrap;

   // Next pointer: clear wins, otherwise step col and carry into row at the wrap.
   always_comb begin
      col_wrap = (col_q == k - k_t'(1));
      row_d    = row_q;
      col_d    = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (advance) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = row_q + k_t'(1);
         end else begin
            col_d = col_q + k_t'(1);
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = col_wrap && (row_q == k - k_t'(1));

endmodule

// File: rtl/pe_cluster_ctrl.sv
// PE cluster sequencer: config latch, weight load, lane clear, ifmap stream, psum count.
module pe_cluster_ctrl
   import pe_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  k_t                 i_filter_width,
   input  r_t                 i_row_num,
   input  k_t                 i_stride,
   input  w_t                 i_ifmap_width,
   pe_cluster_ctrl_if.slave   bus,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output cnt_t               o_psum_cnt
);

   ctrl_state_e           state_q, state_d;
   k_t                    k_q, k_d;
   cnt_t                  ni_q, ni_d;
   cnt_t                  no_q, no_d;
   cnt_t                  if_cnt_q, if_cnt_d;
   cnt_t                  psum_cnt_q, psum_cnt_d;
   logic                  err_q, err_d;
   logic                  w_valid_q, w_valid_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   k_t                    w_row_q, w_row_d;
   k_t                    w_col_q, w_col_d;
   logic                  if_valid_q, if_valid_d;
   logic [DATA_WIDTH-1:0] if_data_q, if_data_d;

   logic cfg_ok;
   logic w_accept;
   logic if_accept;
   logic ptr_clear;
   logic ptr_last;
   k_t   ptr_row;
   k_t   ptr_col;

   pe_wptr_counter u_wptr (
      .clk     (clk),
      .reset   (reset),
      .clear   (ptr_clear),
      .advance (w_accept),
      .k       (k_q),
      .row     (ptr_row),
      .col     (ptr_col),
      .last    (ptr_last)
   );

   // Sequencer next-state: handshakes, registered stream outputs, counters and config latch.
   // R, S and W only matter through NI/NO, so only K and those two totals are kept.
   always_comb begin
      cfg_ok = (i_filter_width != '0) && (i_filter_width <= K_MAX) &&
               (i_row_num != '0) && (i_row_num <= R_MAX) &&
               (i_stride != '0) &&
               (i_ifmap_width >= w_t'(i_filter_width)) && (i_ifmap_width <= W_MAX);
      w_accept   = (state_q == LOAD_W) && bus.i_w_valid;
      if_accept  = (state_q == STREAM) && bus.i_if_valid;
      ptr_clear  = 1'b0;
      state_d    = state_q;
      k_d        = k_q;
      ni_d       = ni_q;
      no_d       = no_q;
      if_cnt_d   = if_cnt_q;
      psum_cnt_d = psum_cnt_q;
      err_d      = 1'b0;
      w_valid_d  = 1'b0;
      w_data_d   = w_data_q;
      w_row_d    = w_row_q;
      w_col_d    = w_col_q;
      if_valid_d = 1'b0;
      if_data_d  = if_data_q;

      if (w_accept) begin
         w_valid_d = 1'b1;
         w_data_d  = bus.i_w_data;
         w_row_d   = ptr_row;
         w_col_d   = ptr_col;
      end

      if (if_accept) begin
         if_valid_d = 1'b1;
         if_data_d  = bus.i_if_data;
         if_cnt_d   = if_cnt_q + cnt_t'(1);
      end

      if ((state_q inside {LOAD_W, CLR, STREAM, DRAIN}) && bus.i_peout_valid &&
          (psum_cnt_q != no_q)) begin
         psum_cnt_d = psum_cnt_q + cnt_t'(1);
      end

      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (cfg_ok) begin
                  k_d        = i_filter_width;
                  ni_d       = calc_ni(i_filter_width, i_row_num, i_stride, i_ifmap_width);
                  no_d       = calc_no(i_filter_width, i_row_num, i_stride, i_ifmap_width);
                  if_cnt_d   = '0;
                  psum_cnt_d = '0;
                  ptr_clear  = 1'b1;
                  state_d    = LOAD_W;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD_W: begin
            if (w_accept && ptr_last) state_d = CLR;
         end
         CLR: begin
            ptr_clear = 1'b1;
            w_row_d   = '0;
            w_col_d   = '0;
            state_d   = STREAM;
         end
         STREAM: begin
            if (if_accept && (if_cnt_q == ni_q - cnt_t'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (psum_cnt_q == no_q) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All sequencer state; async reset returns everything to idle with quiet outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         ni_q       <= '0;
         no_q       <= '0;
         if_cnt_q   <= '0;
         psum_cnt_q <= '0;
         err_q      <= 1'b0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_row_q    <= '0;
         w_col_q    <= '0;
         if_valid_q <= 1'b0;
         if_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         ni_q       <= ni_d;
         no_q       <= no_d;
         if_cnt_q   <= if_cnt_d;
         psum_cnt_q <= psum_cnt_d;
         err_q      <= err_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_row_q    <= w_row_d;
         w_col_q    <= w_col_d;
         if_valid_q <= if_valid_d;
         if_data_q  <= if_data_d;
      end
   end

   assign bus.o_w_ready      = (state_q == LOAD_W);
   assign bus.o_if_ready     = (state_q == STREAM);
   assign bus.o_reset_ifmap  = (state_q == CLR);
   assign bus.o_weight_valid = w_valid_q;
   assign bus.o_weight_data  = w_data_q;
   assign bus.o_wr_w_row_ptr = w_row_q;
   assign bus.o_wr_w_col_ptr = w_col_q;
   assign bus.o_ifmap_valid  = if_valid_q;
   assign bus.o_ifmap_data   = if_data_q;
   assign o_busy             = (state_q != IDLE);
   assign o_done             = (state_q == DONE);
   assign o_err              = err_q;
   assign o_psum_cnt         = psum_cnt_q;

endmodule
